// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one 8-bit add/sub datapath among NREQ requesters.
// Optional macro ALU_ARB_ERR_HALT_EN: an overflow freezes the arbiter in HALT until reset.
module alu_share_arb #(
  parameter int NREQ = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mode,
  input  logic            c6,
  input  logic            c7,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            m,
  output logic            e,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] error,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP, HALT} state_t;

  state_t          state_q;
  logic [SELW-1:0] last_q;
  logic [SELW-1:0] winner_d;
  logic [SELW-1:0] scanIdx_d;
  logic            anyReq_d;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [NREQ-1:0] error_q;
  logic [SELW-1:0] sel_q;
  logic            m_q;
  logic            e_q;
  logic            busy_q;

  // Scan starts just after the previous winner, so the winner itself is checked last.
  always_comb begin
    scanIdx_d = '0;
    winner_d  = '0;
    anyReq_d  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      scanIdx_d = SELW'((int'(last_q) + k) % NREQ);
      if (!anyReq_d && req[scanIdx_d]) begin
        anyReq_d = 1'b1;
        winner_d = scanIdx_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= SELW'(NREQ - 1);
      gnt_q   <= '0;
      sel_q   <= '0;
      m_q     <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= '0;
      error_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            state_q <= EXEC;
            last_q  <= winner_d;
            gnt_q   <= NREQ'(1) << winner_d;
            sel_q   <= winner_d;
            m_q     <= mode[winner_d];
            e_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        // Overflow is captured straight into the response flag of the granted requester.
        EXEC: begin
          state_q <= RESP;
          e_q     <= 1'b0;
          done_q  <= gnt_q;
          error_q <= (c6 ^ c7) ? gnt_q : '0;
        end
        RESP: begin
          done_q <= '0;
`ifdef ALU_ARB_ERR_HALT_EN
          if (|error_q) state_q <= HALT;
          else
`endif
          begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            m_q     <= 1'b0;
            error_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign m     = m_q;
  assign e     = e_q;
  assign done  = done_q;
  assign error = error_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus random traffic
// compared against a job-level round-robin reference model.
module tb_alu_share_arb;
  localparam int NREQ = 4;
  localparam int SELW = 2;
`ifdef ALU_ARB_ERR_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] mode = '0;
  logic            c6 = 1'b0;
  logic            c7 = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [SELW-1:0] sel;
  logic            m;
  logic            e;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] error;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  alu_share_arb #(.NREQ(NREQ), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode), .c6(c6), .c7(c7),
    .gnt(gnt), .sel(sel), .m(m), .e(e), .done(done), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the current job (none / executing / responding / halted).
  int   mLast;
  int   mStage;
  int   mWin;
  logic mMode;
  logic mErr;
  logic [NREQ-1:0] eGnt, eDone, eErr;
  logic [SELW-1:0] eSel;
  logic            eM, eE, eBusy;

  function automatic int rrPick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int gntIndex(input logic [NREQ-1:0] g);
    if ($countones(g) != 1) return -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    mLast = NREQ - 1;
    mStage = 0;
    mWin = 0;
    mMode = 1'b0;
    mErr = 1'b0;
  endtask

  task automatic modelEdge();
    int w;
    case (mStage)
      0: begin
        w = rrPick(mLast, req);
        if (w >= 0) begin
          mWin = w;
          mLast = w;
          mMode = mode[w];
          mStage = 1;
        end
      end
      1: begin
        mErr = c6 ^ c7;
        mStage = 2;
      end
      2: mStage = (HALT_EN && mErr) ? 3 : 0;
      default: mStage = mStage;
    endcase
  endtask

  task automatic modelOutputs();
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << mWin;
    eGnt = '0; eSel = '0; eM = 1'b0; eE = 1'b0; eDone = '0; eErr = '0; eBusy = 1'b0;
    case (mStage)
      1: begin eGnt = oh; eSel = SELW'(mWin); eM = mMode; eE = 1'b1; eBusy = 1'b1; end
      2: begin
        eGnt = oh; eSel = SELW'(mWin); eM = mMode; eDone = oh;
        eErr = mErr ? oh : '0; eBusy = 1'b1;
      end
      3: begin eGnt = oh; eSel = SELW'(mWin); eM = mMode; eErr = oh; eBusy = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] md,
                               input logic a6, input logic a7);
    @(negedge clk);
    req = r; mode = md; c6 = a6; c7 = a7;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    req = '0; mode = '0; c6 = 1'b0; c7 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_gnt got %b want 0000", gnt); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_e got %b want 0", e); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 4'b0000 || error !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL reset_done_err got %b/%b want 0000/0000", done, error);
    end
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    vectors++; if (busy !== 1'b0 || gnt !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL idle_no_req busy/gnt got %b/%b want 0/0000", busy, gnt);
    end
  endtask

  task automatic test_single_job();
    doReset();
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
    vectors++; if (gnt !== 4'b0001 || e !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL single_exec gnt/e/busy got %b/%b/%b want 0001/1/1", gnt, e, busy);
    end
    vectors++; if (sel !== 2'd0 || m !== 1'b0 || done !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL single_exec sel/m/done got %0d/%b/%b want 0/0/0000", sel, m, done);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    vectors++; if (done !== 4'b0001 || error !== 4'b0000 || e !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL single_resp done/err/e/busy got %b/%b/%b/%b want 0001/0000/0/1",
                              done, error, e, busy);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    vectors++; if (done !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL single_after done/busy/gnt got %b/%b/%b want 0000/0/0000", done, busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int when[$];
    doReset();
    for (int cyc = 0; cyc < 16; cyc++) begin
      applyStimulus(4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      if (e === 1'b1) begin
        order.push_back(gntIndex(gnt));
        when.push_back(cyc);
      end
    end
    vectors++;
    if (order.size() < 5) begin
      miscompares++; $display("[TB] FAIL rr_grant_count got %0d want >=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (order[i] != i % NREQ) begin
          miscompares++; $display("[TB] FAIL rr_order[%0d] got %0d want %0d", i, order[i], i % NREQ);
        end
        if (i > 0) begin
          vectors++;
          if (when[i] - when[i-1] != 3) begin
            miscompares++; $display("[TB] FAIL rr_spacing[%0d] got %0d want 3", i, when[i] - when[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_mode_hold();
    doReset();
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
    vectors++; if (m !== 1'b1 || sel !== 2'd2 || gnt !== 4'b0100) begin
      miscompares++; $display("[TB] FAIL mode_exec m/sel/gnt got %b/%0d/%b want 1/2/0100", m, sel, gnt);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    vectors++; if (m !== 1'b1 || sel !== 2'd2 || done !== 4'b0100) begin
      miscompares++; $display("[TB] FAIL mode_resp m/sel/done got %b/%0d/%b want 1/2/0100", m, sel, done);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    doReset();
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
    vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("[TB] FAIL ovf_gnt got %b want 0010", gnt); end
    applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0);
    vectors++; if (done !== 4'b0010 || error !== 4'b0010) begin
      miscompares++; $display("[TB] FAIL ovf_resp done/err got %b/%b want 0010/0010", done, error);
    end
    if (HALT_EN) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
        vectors++;
        if (gnt !== 4'b0010 || error !== 4'b0010 || busy !== 1'b1 || e !== 1'b0 || done !== 4'b0000) begin
          miscompares++; $display("[TB] FAIL halt_hold gnt/err/busy/e/done got %b/%b/%b/%b/%b want 0010/0010/1/0/0000",
                                  gnt, error, busy, e, done);
        end
      end
    end else begin
      applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
      vectors++; if (error !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
        miscompares++; $display("[TB] FAIL ovf_clear err/done/busy got %b/%b/%b want 0000/0000/0", error, done, busy);
      end
      applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
      vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("[TB] FAIL ovf_next_gnt got %b want 0001", gnt); end
    end
  endtask

  task automatic test_reset_midjob();
    doReset();
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    req = '0;
    #1;
    modelReset();
    vectors++; if (gnt !== 4'b0000 || e !== 1'b0 || busy !== 1'b0 || sel !== 2'd0 || m !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset_outs gnt/e/busy/sel/m got %b/%b/%b/%0d/%b want zeros", gnt, e, busy, sel, m);
    end
    @(posedge clk);
    #1;
    vectors++; if (done !== 4'b0000 || error !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL midreset_no_done done/err got %b/%b want 0000/0000", done, error);
    end
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("[TB] FAIL midreset_first_gnt got %b want 0001", gnt); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 15));
      applyStimulus(r, NREQ'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      modelOutputs();
      vectors++; if (gnt !== eGnt) begin miscompares++; $display("[TB] FAIL rand_gnt cyc %0d got %b want %b", cyc, gnt, eGnt); end
      vectors++; if (e !== eE) begin miscompares++; $display("[TB] FAIL rand_e cyc %0d got %b want %b", cyc, e, eE); end
      vectors++; if (done !== eDone) begin miscompares++; $display("[TB] FAIL rand_done cyc %0d got %b want %b", cyc, done, eDone); end
      vectors++; if (error !== eErr) begin miscompares++; $display("[TB] FAIL rand_error cyc %0d got %b want %b", cyc, error, eErr); end
      vectors++; if (busy !== eBusy) begin miscompares++; $display("[TB] FAIL rand_busy cyc %0d got %b want %b", cyc, busy, eBusy); end
      if (mStage != 3) begin
        vectors++; if (sel !== eSel || m !== eM) begin
          miscompares++; $display("[TB] FAIL rand_sel_m cyc %0d got %0d/%b want %0d/%b", cyc, sel, m, eSel, eM);
        end
      end
      vectors++; if ((busy === 1'b1 && $countones(gnt) != 1) || $countones(done) > 1) begin
        miscompares++; $display("[TB] FAIL rand_onehot cyc %0d gnt %b done %b busy %b", cyc, gnt, done, busy);
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_single_job();
    test_round_robin();
    test_mode_hold();
    test_overflow();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one 8-bit add/subtract datapath (operand mux, adder, result register) among `NREQ` requesters. It grants one requester at a time and steers the operand-mux select and add/sub mode. It strobes the result-register enable for exactly one cycle, then checks signed overflow from the adder's carry-into-MSB (`c6`) and carry-out (`c7`). Done and error are returned to the granted requester. It sits between the requester units and the datapath, in place of per-unit private control.

## Interface
- `NREQ`, default 4: number of requesters. Legal values are 2..8.
- `SELW`, default 2: width of `sel`; must equal `$clog2(NREQ)`.
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-low.
- `req`: input, `NREQ` bits. Per-requester job request, level.
- `mode`: input, `NREQ` bits. Per-requester operation: 0 = add, 1 = subtract.
- `c6`: input, 1 bit. Adder carry into bit 7; combinational, valid while `e`=1.
- `c7`: input, 1 bit. Adder carry out of bit 7; combinational, valid while `e`=1.
- `gnt`: output, `NREQ` bits. One-hot grant, registered.
- `sel`: output, `SELW` bits. Operand-mux select, equal to the index of the granted requester.
- `m`: output, 1 bit. Datapath mode, copy of `mode[granted]`.
- `e`: output, 1 bit. Result-register load enable.
- `done`: output, `NREQ` bits. One-cycle completion pulse to the granted requester.
- `error`: output, `NREQ` bits. Overflow flag to the granted requester.
- `busy`: output, 1 bit. High in any state other than IDLE.

## Operation
- Overflow is defined as `ovf = c6 ^ c7`. It is sampled only on the clock edge that ends EXEC.
- The arbiter holds a round-robin pointer `last`, which is the index of the last winner.
- Search order is `last+1`, `last+2`, …, wrapping modulo `NREQ`. The first requester with `req` high wins.
- The state machine has three states, plus HALT when `ALU_ARB_ERR_HALT_EN` is defined.
- **IDLE**
  - `gnt`, `e`, `done`, `error` are 0; `sel` and `m` are 0.
  - If any `req` is high, go to EXEC.
  - The winner index is latched, `gnt[winner]`=1, `sel`=winner, `m`=`mode[winner]`, and `last`=winner.
  - With no request pending, stay in IDLE.
- **EXEC** (one cycle)
  - `e`=1; `gnt`, `sel`, `m` are held.
  - At the closing edge the datapath captures the result, `ovf` is registered, and the state goes to RESP.
- **RESP** (one cycle)
  - `e`=0, `gnt` is held, `done[winner]`=1, `error[winner]`=registered `ovf`.
  - Next state is IDLE. With HALT enabled and `ovf`=1, next state is HALT instead.
- A requester's `req` dropping during EXEC or RESP does not abort the job; it completes normally.
- `mode` is sampled only at grant. Changes after grant are ignored until the next job.
- A requester that keeps `req` high after its `done` is a new request. It waits behind all other pending requesters in round-robin order.
- Reset, including mid-job, forces the following immediately:
  - state=IDLE and `last`=`NREQ`-1, so requester 0 has priority first.
  - All outputs go to 0.
  - Any in-flight job is dropped with no `done`.

## Timing
- Requests are sampled at edge N. `gnt`, `sel`, `m` and `e` are valid from N to N+1.
- `done` and `error` are valid from N+1 to N+2.
- Latency from sampled `req` to `done` is 2 cycles.
- Throughput is 3 cycles per job: back-to-back grants are spaced 3 cycles apart, with one IDLE cycle in between.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Exactly one bit of `gnt` is high whenever `busy`=1. At most one bit of `done` is high in any cycle.

## Configuration
- Macro `ALU_ARB_ERR_HALT_EN` controls what an overflow does.
- **Not defined:** overflow produces only a one-cycle `error[winner]` pulse alongside `done`, and arbitration continues.
- **Defined:**
  - On overflow, RESP goes to HALT instead of IDLE.
  - In HALT, `error[winner]` is held at 1, `gnt[winner]` is held, `busy`=1, `e`=0, `done`=0, and no further grants are issued.
  - HALT is left only through `reset`.
  - Jobs without overflow behave identically to the not-defined build.

## Test plan
- Reset released, then `req`=4'b0001 with `mode[0]`=0 and `c6`=`c7`=0 → `gnt`=0001 and `e`=1 one cycle, then `done`=0001 with `error`=0; `busy` high for 2 cycles.
- `req`=4'b1111 held high continuously → grant order 0,1,2,3,0 with `gnt` edges 3 cycles apart.
- `req`=4'b0100 with `mode[2]`=1; `mode[2]` toggled to 0 during EXEC → `m`=1 for the whole job and `sel`=2.
- `c6`=1, `c7`=0 during EXEC for requester 1:
  - without the macro → `done`=0010 and `error`=0010 for one cycle, then the next grant proceeds.
  - with `ALU_ARB_ERR_HALT_EN` → `error`=0010 held and no further `gnt` until `reset`.
- `reset` asserted low during EXEC → all outputs 0 the same cycle and no `done`. After release with `req`=1111 → requester 0 is granted first.
